jtkicker_mainio: RTL and testbench

Parametrised I/O and interrupt controller for Konami 6809 main boards. It sits between the main CPU's address decoder and the cabinet/video/sound signals. It absorbs the cabinet read mux, the 74LS259 output latch, the VBLANK IRQ flip-flop and the object-frame toggle. It adds a frame-divided NMI, a frame-based watchdog and a configurable sound-IRQ mode, so later boards (Road Fighter successors, dual-NMI games) share one block.

---
 rtl/jtkicker_mainio_pkg.sv | 21 ++
 rtl/jtkicker_ls259.sv | 21 ++
 rtl/jtkicker_mainio.sv | 188 ++++++++++++++++++
 tb/tb_jtkicker_mainio.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkicker_mainio_pkg.sv
// Shared definitions for the Kicker-family main-board I/O block: output latch
// bit map and the cabinet joystick byte packing.
package jtkicker_mainio_pkg;

    localparam int FLIP_BIT  = 0;
    localparam int SND_BIT   = 1;
    localparam int COIN0_BIT = 3;
    localparam int COIN1_BIT = 4;
    localparam int NMIEN_BIT = 6;
    localparam int IRQEN_BIT = 7;

    // Cabinet wiring swaps up/down and left/right relative to the port order
    function automatic logic [7:0] joy_byte(input logic [6:0] joy);
        return {1'b1, joy[6:4], joy[2], joy[3], joy[0], joy[1]};
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtkicker_ls259.sv
// 8-bit addressable latch (74LS259 equivalent) with synchronous clear and
// clock enable.
module jtkicker_ls259 (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic       din,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (cen && we) begin
            q[addr] <= din;
        end
    end

endmodule

// File: rtl/jtkicker_mainio.sv
// Main-board I/O and interrupt controller: cabinet read mux, output latch,
// VBLANK IRQ, frame-divided NMI, frame watchdog and sound IRQ.
module jtkicker_mainio
    import jtkicker_mainio_pkg::*;
#(
    parameter int NMI_DIV      = 0,
    parameter int WDOG_FRAMES  = 0,
    parameter int SNDIRQ_PULSE = 0,
    parameter int JOYW         = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_cen,
    input  logic [2:0]      addr,
    input  logic            rnw,
    input  logic [7:0]      cpu_dout,
    input  logic            iow_cs,
    input  logic            ior_cs,
    input  logic            in5_cs,
    input  logic            intst_cs,
    input  logic            wdog_cs,
    input  logic            LVBL,
    input  logic            dip_pause,
    input  logic [1:0]      start_button,
    input  logic [1:0]      coin_input,
    input  logic            service,
    input  logic [JOYW-1:0] joystick1,
    input  logic [JOYW-1:0] joystick2,
    input  logic [7:0]      dipsw_a,
    input  logic [7:0]      dipsw_b,
    input  logic [2:0]      dipsw_c,
    output logic [7:0]      cab_dout,
    output logic            irq_n,
    output logic            nmi_n,
    output logic            flip,
    output logic            snd_irq,
    output logic            obj_frame,
    output logic [1:0]      coin_cnt,
    output logic            wdog_rst
);

    logic [7:0] latch;
    logic [6:0] joy1_full, joy2_full;
    logic       lvbl_l, vb_edge;
    logic       irq_pend;
    logic       intst_l;
    logic       unused_bits;

    jtkicker_ls259 u_latch (
        .clk  (clk),
        .rst  (rst),
        .cen  (cpu_cen),
        .we   (iow_cs & ~rnw),
        .addr (addr),
        .din  (cpu_dout[0]),
        .q    (latch)
    );

    assign flip     = latch[FLIP_BIT];
    assign coin_cnt = {latch[COIN1_BIT], latch[COIN0_BIT]};
    assign unused_bits = &{1'b0, cpu_dout[7:1], latch[2], latch[5], latch[NMIEN_BIT], wdog_cs};

    // Narrow joystick ports leave the upper cabinet bits reading as released
    always_comb begin
        joy1_full = '1;
        joy2_full = '1;
        joy1_full[JOYW-1:0] = joystick1;
        joy2_full[JOYW-1:0] = joystick2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cab_dout <= 8'hFF;
        end else if (ior_cs) begin
            case (addr[1:0])
                2'd0:    cab_dout <= {dipsw_c, start_button, service, coin_input};
                2'd1:    cab_dout <= joy_byte(joy1_full);
                2'd2:    cab_dout <= joy_byte(joy2_full);
                default: cab_dout <= dipsw_a;
            endcase
        end else if (in5_cs) begin
            cab_dout <= dipsw_b;
        end else begin
            cab_dout <= 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lvbl_l <= 1'b1;
        else     lvbl_l <= LVBL;
    end

    assign vb_edge = lvbl_l & ~LVBL;

    // A cleared enable wins over a simultaneous VBLANK
    always_ff @(posedge clk) begin
        if (rst || !latch[IRQEN_BIT]) irq_pend <= 1'b0;
        else if (vb_edge && dip_pause) irq_pend <= 1'b1;
    end

    assign irq_n = ~irq_pend;

    generate
        if (NMI_DIV > 0) begin : g_nmi
            localparam int NW = cnt_width(NMI_DIV);
            logic [NW-1:0] frame_cnt;
            logic          nmi_pend;
            logic          wrap;

            assign wrap  = vb_edge && (frame_cnt == NW'(NMI_DIV - 1));
            assign nmi_n = ~nmi_pend;

            // The frame counter runs even while NMI is masked
            always_ff @(posedge clk) begin
                if (rst) begin
                    frame_cnt <= '0;
                    nmi_pend  <= 1'b0;
                end else begin
                    if (vb_edge) frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
                    if (!latch[NMIEN_BIT])    nmi_pend <= 1'b0;
                    else if (wrap && dip_pause) nmi_pend <= 1'b1;
                end
            end
        end else begin : g_no_nmi
            assign nmi_n = 1'b1;
        end
    endgenerate

    generate
        if (WDOG_FRAMES > 0) begin : g_wdog
            localparam int WW = cnt_width(WDOG_FRAMES);
            logic [WW-1:0] wdog_cnt;

            // A CPU kick in the same clock as the timeout suppresses the pulse
            always_ff @(posedge clk) begin
                if (rst) begin
                    wdog_cnt <= '0;
                    wdog_rst <= 1'b0;
                end else begin
                    wdog_rst <= 1'b0;
                    if (cpu_cen && wdog_cs) begin
                        wdog_cnt <= '0;
                    end else if (vb_edge) begin
                        if (wdog_cnt == WW'(WDOG_FRAMES - 1)) begin
                            wdog_cnt <= '0;
                            wdog_rst <= 1'b1;
                        end else begin
                            wdog_cnt <= wdog_cnt + 1'b1;
                        end
                    end
                end
            end
        end else begin : g_no_wdog
            assign wdog_rst = 1'b0;
        end
    endgenerate

    generate
        if (SNDIRQ_PULSE != 0) begin : g_snd_pulse
            logic snd_l, snd_pulse;

            always_ff @(posedge clk) begin
                if (rst) begin
                    snd_l     <= 1'b0;
                    snd_pulse <= 1'b0;
                end else if (cpu_cen) begin
                    snd_l     <= latch[SND_BIT];
                    snd_pulse <= latch[SND_BIT] & ~snd_l;
                end
            end

            assign snd_irq = snd_pulse;
        end else begin : g_snd_level
            assign snd_irq = latch[SND_BIT];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            intst_l   <= 1'b0;
            obj_frame <= 1'b0;
        end else if (cpu_cen) begin
            intst_l <= intst_cs;
            if (intst_cs && !intst_l) obj_frame <= ~obj_frame;
        end
    end

endmodule

// File: tb/tb_jtkicker_mainio.sv
// Randomised plus directed bench for jtkicker_mainio, comparing two parameter
// sets against a frame-level behavioural model on every clock.
module tb_jtkicker_mainio;

    localparam int NMI_DIV = 3;
    localparam int WDOG    = 4;

    logic       clk = 1'b0;
    logic       rst, cpu_cen, rnw, iow_cs, ior_cs, in5_cs, intst_cs, wdog_cs;
    logic       LVBL, dip_pause, service;
    logic [2:0] addr, dipsw_c;
    logic [7:0] cpu_dout, dipsw_a, dipsw_b;
    logic [1:0] start_button, coin_input;
    logic [6:0] joystick1, joystick2;

    logic [7:0] cab_a, cab_b;
    logic       irq_n_a, nmi_n_a, flip_a, snd_a, obj_a, wdog_a;
    logic       irq_n_b, nmi_n_b, flip_b, snd_b, obj_b, wdog_b;
    logic [1:0] coin_a, coin_b;

    int checks = 0;
    int failures = 0;
    int nmi_falls, wdog_pulses, snd_rises;
    logic nmi_prev = 1'b1;
    logic snd_prev = 1'b0;

    // Model state
    logic [7:0] m_latch, m_cab_a, m_cab_b;
    logic       m_irq, m_nmi, m_obj, m_intst_l, m_snd_l, m_snd_p, m_wdog, m_lvbl_l;
    int         m_frames, m_wd;

    always #5 clk = ~clk;

    jtkicker_mainio #(.NMI_DIV(NMI_DIV), .WDOG_FRAMES(WDOG), .SNDIRQ_PULSE(1), .JOYW(7)) u_dut_a (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .addr(addr), .rnw(rnw), .cpu_dout(cpu_dout),
        .iow_cs(iow_cs), .ior_cs(ior_cs), .in5_cs(in5_cs), .intst_cs(intst_cs), .wdog_cs(wdog_cs),
        .LVBL(LVBL), .dip_pause(dip_pause), .start_button(start_button), .coin_input(coin_input),
        .service(service), .joystick1(joystick1), .joystick2(joystick2), .dipsw_a(dipsw_a),
        .dipsw_b(dipsw_b), .dipsw_c(dipsw_c), .cab_dout(cab_a), .irq_n(irq_n_a), .nmi_n(nmi_n_a),
        .flip(flip_a), .snd_irq(snd_a), .obj_frame(obj_a), .coin_cnt(coin_a), .wdog_rst(wdog_a)
    );

    jtkicker_mainio #(.NMI_DIV(0), .WDOG_FRAMES(0), .SNDIRQ_PULSE(0), .JOYW(5)) u_dut_b (
        .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .addr(addr), .rnw(rnw), .cpu_dout(cpu_dout),
        .iow_cs(iow_cs), .ior_cs(ior_cs), .in5_cs(in5_cs), .intst_cs(intst_cs), .wdog_cs(wdog_cs),
        .LVBL(LVBL), .dip_pause(dip_pause), .start_button(start_button), .coin_input(coin_input),
        .service(service), .joystick1(joystick1[4:0]), .joystick2(joystick2[4:0]), .dipsw_a(dipsw_a),
        .dipsw_b(dipsw_b), .dipsw_c(dipsw_c), .cab_dout(cab_b), .irq_n(irq_n_b), .nmi_n(nmi_n_b),
        .flip(flip_b), .snd_irq(snd_b), .obj_frame(obj_b), .coin_cnt(coin_b), .wdog_rst(wdog_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Cabinet byte as seen through the wiring: up/down and left/right swapped
    function automatic logic [7:0] cabModel(input logic [6:0] j1, input logic [6:0] j2);
        logic [6:0] j;
        logic [7:0] v;
        if (!ior_cs) return in5_cs ? dipsw_b : 8'hFF;
        if (addr[1:0] == 2'd0) return {dipsw_c, start_button, service, coin_input};
        if (addr[1:0] == 2'd3) return dipsw_a;
        j = (addr[1:0] == 2'd1) ? j1 : j2;
        v[7] = 1'b1; v[6:4] = j[6:4]; v[3] = j[2]; v[2] = j[3]; v[1] = j[0]; v[0] = j[1];
        return v;
    endfunction

    // Evaluated with the input values present at the clock edge
    task automatic modelStep();
        logic edge_v, wrap;
        if (rst) begin
            m_latch = 8'h00; m_irq = 0; m_nmi = 0; m_frames = 0; m_wd = 0; m_obj = 0;
            m_intst_l = 0; m_snd_l = 0; m_snd_p = 0; m_wdog = 0; m_lvbl_l = 1;
            m_cab_a = 8'hFF; m_cab_b = 8'hFF;
            return;
        end
        edge_v = m_lvbl_l && !LVBL;
        m_lvbl_l = LVBL;
        if (!m_latch[7]) m_irq = 0; else if (edge_v && dip_pause) m_irq = 1;
        wrap = 0;
        if (edge_v) begin
            m_frames++;
            wrap = (m_frames % NMI_DIV) == 0;
        end
        if (!m_latch[6]) m_nmi = 0; else if (wrap && dip_pause) m_nmi = 1;
        m_wdog = 0;
        if (cpu_cen && wdog_cs) m_wd = 0;
        else if (edge_v) begin
            m_wd++;
            if (m_wd == WDOG) begin m_wdog = 1; m_wd = 0; end
        end
        if (cpu_cen) begin
            m_snd_p = m_latch[1] && !m_snd_l;
            m_snd_l = m_latch[1];
            if (intst_cs && !m_intst_l) m_obj = !m_obj;
            m_intst_l = intst_cs;
        end
        if (cpu_cen && iow_cs && !rnw) m_latch[addr] = cpu_dout[0];
        m_cab_a = cabModel(joystick1, joystick2);
        m_cab_b = cabModel({2'b11, joystick1[4:0]}, {2'b11, joystick2[4:0]});
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #2;
        checkOutput("cab_a", cab_a, m_cab_a);
        checkOutput("irq_a", irq_n_a, !m_irq);
        checkOutput("nmi_a", nmi_n_a, !m_nmi);
        checkOutput("flip_a", flip_a, m_latch[0]);
        checkOutput("coin_a", coin_a, {m_latch[4], m_latch[3]});
        checkOutput("snd_a", snd_a, m_snd_p);
        checkOutput("obj_a", obj_a, m_obj);
        checkOutput("wdog_a", wdog_a, m_wdog);
        checkOutput("cab_b", cab_b, m_cab_b);
        checkOutput("irq_b", irq_n_b, !m_irq);
        checkOutput("nmi_b", nmi_n_b, 1'b1);
        checkOutput("flip_b", flip_b, m_latch[0]);
        checkOutput("coin_b", coin_b, {m_latch[4], m_latch[3]});
        checkOutput("snd_b", snd_b, m_latch[1]);
        checkOutput("obj_b", obj_b, m_obj);
        checkOutput("wdog_b", wdog_b, 1'b0);
        if (nmi_prev && !nmi_n_a) nmi_falls++;
        if (!snd_prev && snd_a) snd_rises++;
        if (wdog_a) wdog_pulses++;
        nmi_prev = nmi_n_a;
        snd_prev = snd_a;
    endtask

    task automatic idleInputs();
        rst = 0; cpu_cen = 0; rnw = 1; iow_cs = 0; ior_cs = 0; in5_cs = 0;
        intst_cs = 0; wdog_cs = 0; LVBL = 1; dip_pause = 1; addr = 3'd0; cpu_dout = 8'h00;
    endtask

    task automatic applyStimulus(input int cyc);
        int fpos;
        fpos         = cyc % 48;
        rst          = ($urandom_range(0, 999) == 0);
        cpu_cen      = ($urandom_range(0, 3) == 0);
        iow_cs       = ($urandom_range(0, 4) == 0);
        rnw          = ($urandom_range(0, 3) == 0);
        addr         = 3'($urandom_range(0, 7));
        cpu_dout     = 8'($urandom);
        if (addr >= 3'd6) cpu_dout[0] = ($urandom_range(0, 3) != 0);
        ior_cs       = ($urandom_range(0, 1) == 0);
        in5_cs       = ($urandom_range(0, 3) == 0);
        intst_cs     = ($urandom_range(0, 2) == 0);
        wdog_cs      = ($urandom_range(0, 150) == 0);
        LVBL         = (fpos >= 8);
        dip_pause    = ($urandom_range(0, 9) != 0);
        service      = 1'($urandom);
        start_button = 2'($urandom);
        coin_input   = 2'($urandom);
        joystick1    = 7'($urandom);
        joystick2    = 7'($urandom);
        dipsw_a      = 8'($urandom);
        dipsw_b      = 8'($urandom);
        dipsw_c      = 3'($urandom);
    endtask

    task automatic cpuWrite(input logic [2:0] bitn, input logic val);
        addr = bitn; cpu_dout = {7'd0, val}; iow_cs = 1; rnw = 0; cpu_cen = 1;
        tick();
        iow_cs = 0; rnw = 1; cpu_cen = 0;
        tick();
    endtask

    task automatic frame(input logic kick);
        LVBL = 0; wdog_cs = kick; cpu_cen = kick;
        tick();
        wdog_cs = 0; cpu_cen = 0;
        repeat (3) tick();
        LVBL = 1;
        repeat (3) tick();
    endtask

    task automatic resetPulse();
        idleInputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        logic obj_before;
        idleInputs();
        service = 0; start_button = 0; coin_input = 0; joystick1 = 0; joystick2 = 0;
        dipsw_a = 8'h00; dipsw_b = 8'h00; dipsw_c = 3'd0;
        resetPulse();
        checkOutput("rst_irq_n", irq_n_a, 1'b1);
        checkOutput("rst_nmi_n", nmi_n_a, 1'b1);
        checkOutput("rst_cab", cab_a, 8'hFF);
        checkOutput("rst_wdog", wdog_a, 1'b0);

        $display("[TB] randomised phase");
        for (int cyc = 0; cyc < 4000; cyc++) begin
            applyStimulus(cyc);
            tick();
        end

        $display("[TB] directed: IRQ");
        resetPulse();
        cpuWrite(3'd7, 1'b1);
        LVBL = 0;
        tick();
        checkOutput("irq_set", irq_n_a, 1'b0);
        LVBL = 1;
        repeat (2) tick();
        cpuWrite(3'd7, 1'b0);
        checkOutput("irq_clr", irq_n_a, 1'b1);
        cpuWrite(3'd7, 1'b1);
        dip_pause = 0;
        LVBL = 0;
        repeat (2) tick();
        checkOutput("irq_pause", irq_n_a, 1'b1);
        LVBL = 1; dip_pause = 1;
        tick();

        $display("[TB] directed: NMI divider");
        resetPulse();
        cpuWrite(3'd6, 1'b1);
        nmi_falls = 0;
        for (int f = 0; f < 6; f++) begin
            frame(1'b0);
            if (!nmi_n_a) begin
                cpuWrite(3'd6, 1'b0);
                cpuWrite(3'd6, 1'b1);
            end
        end
        checkOutput("nmi_count", 8'(nmi_falls), 8'd2);

        $display("[TB] directed: watchdog");
        resetPulse();
        wdog_pulses = 0;
        repeat (3) frame(1'b0);
        frame(1'b1);
        checkOutput("wdog_kick", 8'(wdog_pulses), 8'd0);
        repeat (4) frame(1'b0);
        checkOutput("wdog_timeout", 8'(wdog_pulses), 8'd1);

        $display("[TB] directed: cabinet mux");
        ior_cs = 1; addr = 3'd1; joystick1 = 7'b0000101;
        tick();
        ior_cs = 0; in5_cs = 1; dipsw_b = 8'h5A;
        tick();
        checkOutput("cab_in5", cab_a, 8'h5A);
        in5_cs = 0;
        tick();
        checkOutput("cab_none", cab_a, 8'hFF);

        $display("[TB] directed: sound IRQ");
        resetPulse();
        snd_rises = 0;
        cpuWrite(3'd1, 1'b1);
        cpuWrite(3'd1, 1'b1);
        repeat (4) begin
            cpu_cen = 1; tick();
            cpu_cen = 0; tick();
        end
        checkOutput("snd_pulses", 8'(snd_rises), 8'd1);
        checkOutput("snd_level_hold", snd_b, 1'b1);
        cpuWrite(3'd1, 1'b0);
        checkOutput("snd_level_clr", snd_b, 1'b0);

        $display("[TB] directed: obj_frame and mid-frame reset");
        cpu_cen = 1; intst_cs = 0;
        tick();
        obj_before = obj_a;
        intst_cs = 1;
        repeat (3) begin
            cpu_cen = 1; tick();
            cpu_cen = 0; tick();
        end
        intst_cs = 0;
        checkOutput("obj_toggle", obj_a, !obj_before);
        cpuWrite(3'd0, 1'b1);
        cpuWrite(3'd3, 1'b1);
        cpuWrite(3'd7, 1'b1);
        LVBL = 0; ior_cs = 1; addr = 3'd3;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checkOutput("mid_irq_n", irq_n_a, 1'b1);
        checkOutput("mid_flip", flip_a, 1'b0);
        checkOutput("mid_coin", coin_a, 2'b00);
        checkOutput("mid_obj", obj_a, 1'b0);
        checkOutput("mid_cab", cab_a, 8'hFF);
        checkOutput("mid_snd", snd_a, 1'b0);
        LVBL = 1; ior_cs = 0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
